// File: rtl/ysyx_25040129_lsu_pkg.sv
// ============================================================================
// Module   : ysyx_25040129_lsu_pkg
// Brief    : Shared encodings, FSM states and alignment helper for the LSU.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package ysyx_25040129_lsu_pkg;

    localparam int WORD_T = 4;

    localparam logic [2:0] NO_MEM_READ = 3'd0;
    localparam logic [2:0] LB          = 3'd1;
    localparam logic [2:0] LH          = 3'd2;
    localparam logic [2:0] LW          = 3'd3;
    localparam logic [2:0] LBU         = 3'd4;
    localparam logic [2:0] LHU         = 3'd5;

    localparam logic [1:0] NO_MEM_WRITE = 2'd0;
    localparam logic [1:0] SB           = 2'd1;
    localparam logic [1:0] SH           = 2'd2;
    localparam logic [1:0] SW           = 2'd3;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BUS_REQ  = 2'd1,
        BUS_WAIT = 2'd2,
        WB_HOLD  = 2'd3
    } lsu_state_e;

    // A request carrying both a load and a store kind behaves as the store.
    function automatic logic is_misaligned(input logic [2:0] rd_kind,
                                           input logic [1:0] wr_kind,
                                           input logic [1:0] off);
        logic [2:0] eff_read;
        eff_read      = (wr_kind != NO_MEM_WRITE) ? NO_MEM_READ : rd_kind;
        is_misaligned = 1'b0;
        if (wr_kind == SH || eff_read == LH || eff_read == LHU) begin
            is_misaligned = off[0];
        end else if (wr_kind == SW || eff_read == LW) begin
            is_misaligned = (off != 2'b00);
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/ysyx_25040129_lsu_align.sv
// ============================================================================
// Module   : ysyx_25040129_lsu_align
// Brief    : Store lane/strobe generation and load byte/half extract + extend.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25040129_lsu_align
    import ysyx_25040129_lsu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [1:0]        off,
    input  logic [1:0]        store_kind,
    input  logic [XLEN-1:0]   store_data,
    input  logic [2:0]        load_kind,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN-1:0]   wdata,
    output logic [WORD_T-1:0] wstrb,
    output logic [XLEN-1:0]   load_result
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        wdata = store_data;
        wstrb = '0;
        case (store_kind)
            SB: begin
                wdata = {(XLEN/8){store_data[7:0]}};
                wstrb = 4'b0001 << off;
            end
            SH: begin
                wdata = {(XLEN/16){store_data[15:0]}};
                wstrb = 4'b0011 << off;
            end
            SW: begin
                wdata = store_data;
                wstrb = '1;
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte      = rdata[8*off +: 8];
        w_half      = rdata[16*off[1] +: 16];
        load_result = '0;
        case (load_kind)
            LB:      load_result = {{(XLEN-8){w_byte[7]}}, w_byte};
            LH:      load_result = {{(XLEN-16){w_half[15]}}, w_half};
            LW:      load_result = rdata;
            LBU:     load_result = {{(XLEN-8){1'b0}}, w_byte};
            LHU:     load_result = {{(XLEN-16){1'b0}}, w_half};
            default: load_result = '0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ysyx_25040129_lsu.sv
// ============================================================================
// Module   : ysyx_25040129_lsu
// Brief    : EXU->WBU memory stage, single-outstanding data bus access.
//            Define YSYX_25040129_LSU_ALIGN_CHECK_EN to fault misaligned
//            accesses without issuing them on the bus.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ysyx_25040129_lsu
    import ysyx_25040129_lsu_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int REGS_DIG = 5,
    parameter int CTRL_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                is_req_valid_from_exu,
    output logic                is_req_ready_to_exu,
    input  logic [XLEN-1:0]     addr_in_lsu,
    input  logic [XLEN-1:0]     lsu_write_data_in_lsu,
    input  logic [2:0]          lsu_read_in_lsu,
    input  logic [1:0]          lsu_write_in_lsu,
    input  logic [REGS_DIG-1:0] rd_in_lsu,
    input  logic                reg_write_in_lsu,
    input  logic [CTRL_W-1:0]   ctrl_in_lsu,
    output logic                mem_req_valid,
    input  logic                mem_req_ready,
    output logic                mem_we,
    output logic [XLEN-1:0]     mem_addr,
    output logic [XLEN-1:0]     mem_wdata,
    output logic [3:0]          mem_wstrb,
    input  logic                mem_rsp_valid,
    input  logic [XLEN-1:0]     mem_rdata,
    input  logic                mem_rsp_err,
    output logic                is_req_valid_to_wbu,
    input  logic                is_req_ready_from_wbu,
    output logic [XLEN-1:0]     result_out_lsu,
    output logic [REGS_DIG-1:0] rd_out_lsu,
    output logic                reg_write_out_lsu,
    output logic [CTRL_W-1:0]   ctrl_out_lsu,
    output logic                lsu_err_out,
    output logic                is_data_forward_valid_from_lsu
);

    lsu_state_e          r_state;
    lsu_state_e          w_next_state;
    logic [XLEN-1:0]     r_addr;
    logic [XLEN-1:0]     r_store_data;
    logic [XLEN-1:0]     r_result;
    logic [2:0]          r_read;
    logic [1:0]          r_write;
    logic [REGS_DIG-1:0] r_rd;
    logic                r_reg_write;
    logic [CTRL_W-1:0]   r_ctrl;
    logic                r_err;
    logic                w_accept;
    logic                w_is_mem;
    logic                w_misaligned;
    logic                w_bus_done;
    logic [XLEN-1:0]     w_load_result;

    assign w_accept = is_req_valid_from_exu && is_req_ready_to_exu;
    assign w_is_mem = (lsu_read_in_lsu != NO_MEM_READ) || (lsu_write_in_lsu != NO_MEM_WRITE);

`ifdef YSYX_25040129_LSU_ALIGN_CHECK_EN
    assign w_misaligned = is_misaligned(lsu_read_in_lsu, lsu_write_in_lsu, addr_in_lsu[1:0]);
`else
    assign w_misaligned = 1'b0;
`endif

    // A response is only meaningful once our request has been taken.
    assign w_bus_done = mem_rsp_valid &&
                        ((r_state == BUS_WAIT) || ((r_state == BUS_REQ) && mem_req_ready));

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next_state = (w_is_mem && !w_misaligned) ? BUS_REQ : WB_HOLD;
            end
            BUS_REQ: begin
                if (mem_req_ready) w_next_state = mem_rsp_valid ? WB_HOLD : BUS_WAIT;
            end
            BUS_WAIT: begin
                if (mem_rsp_valid) w_next_state = WB_HOLD;
            end
            WB_HOLD: begin
                if (is_req_ready_from_wbu) w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        is_req_ready_to_exu            = (r_state == IDLE) && !rst;
        mem_req_valid                  = (r_state == BUS_REQ);
        is_req_valid_to_wbu            = (r_state == WB_HOLD);
        is_data_forward_valid_from_lsu = (r_state == WB_HOLD) && r_reg_write;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr       <= '0;
            r_store_data <= '0;
            r_result     <= '0;
            r_read       <= NO_MEM_READ;
            r_write      <= NO_MEM_WRITE;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_ctrl       <= '0;
            r_err        <= 1'b0;
        end else if (w_accept) begin
            r_addr       <= addr_in_lsu;
            r_store_data <= lsu_write_data_in_lsu;
            r_read       <= (lsu_write_in_lsu != NO_MEM_WRITE) ? NO_MEM_READ : lsu_read_in_lsu;
            r_write      <= lsu_write_in_lsu;
            r_rd         <= rd_in_lsu;
            r_reg_write  <= reg_write_in_lsu && (lsu_write_in_lsu == NO_MEM_WRITE) && !w_misaligned;
            r_ctrl       <= ctrl_in_lsu;
            r_result     <= w_is_mem ? '0 : addr_in_lsu;
            r_err        <= w_misaligned;
        end else if (w_bus_done) begin
            if (mem_rsp_err) begin
                r_result    <= '0;
                r_reg_write <= 1'b0;
                r_err       <= 1'b1;
            end else begin
                r_result <= (r_write != NO_MEM_WRITE) ? '0 : w_load_result;
            end
        end
    end

    ysyx_25040129_lsu_align #(
        .XLEN (XLEN)
    ) u_align (
        .off         (r_addr[1:0]),
        .store_kind  (r_write),
        .store_data  (r_store_data),
        .load_kind   (r_read),
        .rdata       (mem_rdata),
        .wdata       (mem_wdata),
        .wstrb       (mem_wstrb),
        .load_result (w_load_result)
    );

    assign mem_we            = (r_write != NO_MEM_WRITE);
    assign mem_addr          = r_addr;
    assign result_out_lsu    = r_result;
    assign rd_out_lsu        = r_rd;
    assign reg_write_out_lsu = r_reg_write;
    assign ctrl_out_lsu      = r_ctrl;
    assign lsu_err_out       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_ysyx_25040129_lsu.sv
// ============================================================================
// Module   : tb_ysyx_25040129_lsu
// Brief    : Self-checking bench for ysyx_25040129_lsu with a reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ysyx_25040129_lsu;
    import ysyx_25040129_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_req_valid_from_exu;
    logic        is_req_ready_to_exu;
    logic [31:0] addr_in_lsu;
    logic [31:0] lsu_write_data_in_lsu;
    logic [2:0]  lsu_read_in_lsu;
    logic [1:0]  lsu_write_in_lsu;
    logic [4:0]  rd_in_lsu;
    logic        reg_write_in_lsu;
    logic [15:0] ctrl_in_lsu;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        mem_rsp_err;
    logic        is_req_valid_to_wbu;
    logic        is_req_ready_from_wbu;
    logic [31:0] result_out_lsu;
    logic [4:0]  rd_out_lsu;
    logic        reg_write_out_lsu;
    logic [15:0] ctrl_out_lsu;
    logic        lsu_err_out;
    logic        is_data_forward_valid_from_lsu;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    ysyx_25040129_lsu #(.XLEN(32), .REGS_DIG(5), .CTRL_W(16)) dut (
        .clk                            (clk),
        .rst                            (rst),
        .is_req_valid_from_exu          (is_req_valid_from_exu),
        .is_req_ready_to_exu            (is_req_ready_to_exu),
        .addr_in_lsu                    (addr_in_lsu),
        .lsu_write_data_in_lsu          (lsu_write_data_in_lsu),
        .lsu_read_in_lsu                (lsu_read_in_lsu),
        .lsu_write_in_lsu               (lsu_write_in_lsu),
        .rd_in_lsu                      (rd_in_lsu),
        .reg_write_in_lsu               (reg_write_in_lsu),
        .ctrl_in_lsu                    (ctrl_in_lsu),
        .mem_req_valid                  (mem_req_valid),
        .mem_req_ready                  (mem_req_ready),
        .mem_we                         (mem_we),
        .mem_addr                       (mem_addr),
        .mem_wdata                      (mem_wdata),
        .mem_wstrb                      (mem_wstrb),
        .mem_rsp_valid                  (mem_rsp_valid),
        .mem_rdata                      (mem_rdata),
        .mem_rsp_err                    (mem_rsp_err),
        .is_req_valid_to_wbu            (is_req_valid_to_wbu),
        .is_req_ready_from_wbu          (is_req_ready_from_wbu),
        .result_out_lsu                 (result_out_lsu),
        .rd_out_lsu                     (rd_out_lsu),
        .reg_write_out_lsu              (reg_write_out_lsu),
        .ctrl_out_lsu                   (ctrl_out_lsu),
        .lsu_err_out                    (lsu_err_out),
        .is_data_forward_valid_from_lsu (is_data_forward_valid_from_lsu)
    );

    // Reference model: what the access should look like and what it should return.
    function automatic void model(input logic [2:0] rk, input logic [1:0] wk,
                                  input logic [31:0] addr, input logic [31:0] data,
                                  input logic [31:0] rdata, input logic rw, input logic err,
                                  output logic is_mem, output logic mis, output logic we,
                                  output logic [31:0] wdata, output logic [3:0] wstrb,
                                  output logic [31:0] res, output logic rw_o, output logic err_o);
        int unsigned off, size;
        logic [31:0] b, h, val;
        logic is_store, is_load;
        off      = addr % 4;
        is_store = (wk != 0);
        is_load  = !is_store && (rk != 0);
        is_mem   = is_store || is_load;
        we       = is_store;
        size     = 4;
        if (is_store) size = (wk == SB) ? 1 : (wk == SH) ? 2 : 4;
        else if (rk == LB || rk == LBU) size = 1;
        else if (rk == LH || rk == LHU) size = 2;
        mis = 1'b0;
`ifdef YSYX_25040129_LSU_ALIGN_CHECK_EN
        mis = is_mem && ((off % size) != 0);
`endif
        wdata = data;
        wstrb = 4'h0;
        if (wk == SB)      begin wdata = (data & 32'hFF) * 32'h0101_0101;  wstrb = 4'((1 << off) & 15); end
        else if (wk == SH) begin wdata = (data & 32'hFFFF) * 32'h0001_0001; wstrb = 4'((3 << off) & 15); end
        else if (wk == SW) begin wdata = data; wstrb = 4'hF; end
        b = (rdata >> (8 * off)) & 32'hFF;
        h = (rdata >> (16 * (off / 2))) & 32'hFFFF;
        case (rk)
            LB:      val = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            LH:      val = (h >= 32768) ? h + 32'hFFFF_0000 : h;
            LW:      val = rdata;
            LBU:     val = b;
            LHU:     val = h;
            default: val = 0;
        endcase
        if (mis || (is_mem && err)) begin res = 0; rw_o = 0; err_o = 1; end
        else if (!is_mem)           begin res = addr; rw_o = rw; err_o = 0; end
        else if (is_store)          begin res = 0; rw_o = 0; err_o = 0; end
        else                        begin res = val; rw_o = rw; err_o = 0; end
    endfunction

    // Entered and left at a negedge with the DUT in IDLE. rsp_lat < 0 means
    // the response arrives in the same cycle the bus accepts the request.
    task automatic do_op(input string tag, input logic [2:0] rk, input logic [1:0] wk,
                         input logic [31:0] addr, input logic [31:0] data,
                         input logic [4:0] rd, input logic rw, input logic [15:0] ctrl,
                         input logic [31:0] rdata, input logic err,
                         input int req_lat, input int rsp_lat, input int wb_lat);
        logic is_mem, mis, we, rw_o, err_o;
        logic [31:0] wdata, res;
        logic [3:0] wstrb;
        model(rk, wk, addr, data, rdata, rw, err, is_mem, mis, we, wdata, wstrb, res, rw_o, err_o);

        n_total++;
        if (is_req_ready_to_exu !== 1'b1) $display("FAIL %s idle_ready: got %b exp 1", tag, is_req_ready_to_exu);
        else n_pass++;

        is_req_valid_from_exu = 1'b1;
        addr_in_lsu = addr; lsu_write_data_in_lsu = data;
        lsu_read_in_lsu = rk; lsu_write_in_lsu = wk;
        rd_in_lsu = rd; reg_write_in_lsu = rw; ctrl_in_lsu = ctrl;
        @(negedge clk);
        is_req_valid_from_exu = 1'b0;
        addr_in_lsu = $urandom; lsu_write_data_in_lsu = $urandom;
        rd_in_lsu = 5'($urandom); ctrl_in_lsu = 16'($urandom); reg_write_in_lsu = ~rw;

        if (is_mem && !mis) begin
            for (int i = 0; i <= req_lat; i++) begin
                if (i > 0) @(negedge clk);
                n_total++;
                if ({mem_req_valid, mem_we, mem_addr, is_req_ready_to_exu, is_req_valid_to_wbu} !==
                    {1'b1, we, addr, 1'b0, 1'b0})
                    $display("FAIL %s bus_req: got v=%b we=%b a=%h rdy=%b wbv=%b exp v=1 we=%b a=%h rdy=0 wbv=0",
                             tag, mem_req_valid, mem_we, mem_addr, is_req_ready_to_exu, is_req_valid_to_wbu, we, addr);
                else n_pass++;
                if (we) begin
                    n_total++;
                    if ({mem_wdata, mem_wstrb} !== {wdata, wstrb})
                        $display("FAIL %s store_lanes: got wdata=%h wstrb=%b exp wdata=%h wstrb=%b",
                                 tag, mem_wdata, mem_wstrb, wdata, wstrb);
                    else n_pass++;
                end
            end
            mem_req_ready = 1'b1;
            if (rsp_lat < 0) begin
                mem_rsp_valid = 1'b1; mem_rdata = rdata; mem_rsp_err = err;
            end
            @(negedge clk);
            mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rdata = $urandom;
            if (rsp_lat >= 0) begin
                for (int i = 0; i <= rsp_lat; i++) begin
                    if (i > 0) @(negedge clk);
                    n_total++;
                    if ({mem_req_valid, is_req_valid_to_wbu, is_req_ready_to_exu} !== 3'b000)
                        $display("FAIL %s bus_wait: got req=%b wbv=%b rdy=%b exp 0 0 0",
                                 tag, mem_req_valid, is_req_valid_to_wbu, is_req_ready_to_exu);
                    else n_pass++;
                end
                mem_rsp_valid = 1'b1; mem_rdata = rdata; mem_rsp_err = err;
                @(negedge clk);
                mem_rsp_valid = 1'b0; mem_rsp_err = 1'b0; mem_rdata = $urandom;
            end
        end else begin
            n_total++;
            if (mem_req_valid !== 1'b0) $display("FAIL %s no_bus: got req=%b exp 0", tag, mem_req_valid);
            else n_pass++;
        end

        for (int i = 0; i <= wb_lat; i++) begin
            if (i > 0) @(negedge clk);
            n_total++;
            if ({is_req_valid_to_wbu, result_out_lsu, rd_out_lsu, reg_write_out_lsu, ctrl_out_lsu,
                 lsu_err_out, is_data_forward_valid_from_lsu, is_req_ready_to_exu, mem_req_valid} !==
                {1'b1, res, rd, rw_o, ctrl, err_o, rw_o, 1'b0, 1'b0})
                $display("FAIL %s wb: got v=%b res=%h rd=%0d rw=%b ctrl=%h err=%b fwd=%b rdy=%b req=%b exp v=1 res=%h rd=%0d rw=%b ctrl=%h err=%b fwd=%b rdy=0 req=0",
                         tag, is_req_valid_to_wbu, result_out_lsu, rd_out_lsu, reg_write_out_lsu, ctrl_out_lsu,
                         lsu_err_out, is_data_forward_valid_from_lsu, is_req_ready_to_exu, mem_req_valid,
                         res, rd, rw_o, ctrl, err_o, rw_o);
            else n_pass++;
        end
        is_req_ready_from_wbu = 1'b1;
        @(negedge clk);
        is_req_ready_from_wbu = 1'b0;
        n_total++;
        if ({is_req_valid_to_wbu, is_req_ready_to_exu} !== 2'b01)
            $display("FAIL %s wb_done: got wbv=%b rdy=%b exp wbv=0 rdy=1", tag, is_req_valid_to_wbu, is_req_ready_to_exu);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({is_req_ready_to_exu, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, is_req_valid_to_wbu,
             result_out_lsu, rd_out_lsu, reg_write_out_lsu, ctrl_out_lsu, lsu_err_out,
             is_data_forward_valid_from_lsu} !== '0)
            $display("FAIL reset_outputs: got rdy=%b req=%b we=%b a=%h wd=%h ws=%b wbv=%b res=%h rd=%0d rw=%b ctrl=%h err=%b fwd=%b exp all 0",
                     is_req_ready_to_exu, mem_req_valid, mem_we, mem_addr, mem_wdata, mem_wstrb, is_req_valid_to_wbu,
                     result_out_lsu, rd_out_lsu, reg_write_out_lsu, ctrl_out_lsu, lsu_err_out,
                     is_data_forward_valid_from_lsu);
        else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_total++;
        if (is_req_ready_to_exu !== 1'b1) $display("FAIL reset_release_ready: got %b exp 1", is_req_ready_to_exu);
        else n_pass++;
    endtask

    task automatic test_alu_passthrough();
        do_op("alu", NO_MEM_READ, NO_MEM_WRITE, 32'h0000_1234, 32'h0, 5'd5, 1'b1, 16'hA5A5, 32'h0, 1'b0, 0, 0, 0);
    endtask

    task automatic test_store_lanes();
        do_op("sb_off3", NO_MEM_READ, SB, 32'h8000_0003, 32'h0000_00AB, 5'd7, 1'b1, 16'h0001, 32'h0, 1'b0, 0, 0, 0);
        do_op("sh_off2", NO_MEM_READ, SH, 32'h8000_0006, 32'hDEAD_BEEF, 5'd8, 1'b0, 16'h0002, 32'h0, 1'b0, 1, -1, 0);
    endtask

    task automatic test_loads();
        do_op("lb",  LB,  NO_MEM_WRITE, 32'h8000_0002, 32'h0, 5'd9,  1'b1, 16'h0003, 32'h1280_FF00, 1'b0, 0, 0, 0);
        do_op("lbu", LBU, NO_MEM_WRITE, 32'h8000_0002, 32'h0, 5'd10, 1'b1, 16'h0004, 32'h1280_FF00, 1'b0, 0, -1, 0);
        do_op("lhu", LHU, NO_MEM_WRITE, 32'h8000_0002, 32'h0, 5'd11, 1'b1, 16'h0005, 32'h1280_FF00, 1'b0, 0, 1, 0);
        do_op("lh_off3", LH, NO_MEM_WRITE, 32'h8000_0003, 32'h0, 5'd12, 1'b1, 16'h0006, 32'h9234_5678, 1'b0, 0, 0, 0);
    endtask

    task automatic test_backpressure();
        do_op("bp_sw", NO_MEM_READ, SW, 32'h8000_0010, 32'h1357_9BDF, 5'd3, 1'b1, 16'h00FF, 32'h0, 1'b0, 3, 1, 2);
        do_op("bp_lw", LW, NO_MEM_WRITE, 32'h8000_0014, 32'h0, 5'd4, 1'b1, 16'h0F0F, 32'hCAFE_F00D, 1'b0, 3, 0, 2);
    endtask

    task automatic test_bus_error();
        do_op("lw_err", LW, NO_MEM_WRITE, 32'h8000_0020, 32'h0, 5'd6, 1'b1, 16'h1111, 32'h1234_5678, 1'b1, 0, 1, 0);
        do_op("lw_mis", LW, NO_MEM_WRITE, 32'h8000_0002, 32'h0, 5'd6, 1'b1, 16'h2222, 32'h8765_4321, 1'b0, 0, 0, 0);
        do_op("illegal_rw", LBU, SB, 32'h8000_0021, 32'h0000_0077, 5'd2, 1'b1, 16'h3333, 32'hFFFF_FFFF, 1'b0, 0, 0, 0);
    endtask

    task automatic test_reset_midop();
        is_req_valid_from_exu = 1'b1;
        addr_in_lsu = 32'h8000_0040; lsu_read_in_lsu = LW; lsu_write_in_lsu = NO_MEM_WRITE;
        rd_in_lsu = 5'd1; reg_write_in_lsu = 1'b1; ctrl_in_lsu = 16'h4444;
        @(negedge clk);
        is_req_valid_from_exu = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        n_total++;
        if ({is_req_ready_to_exu, is_req_valid_to_wbu, mem_req_valid, result_out_lsu, reg_write_out_lsu} !== '0)
            $display("FAIL midop_in_reset: got rdy=%b wbv=%b req=%b res=%h rw=%b exp all 0",
                     is_req_ready_to_exu, is_req_valid_to_wbu, mem_req_valid, result_out_lsu, reg_write_out_lsu);
        else n_pass++;
        rst = 1'b0;
        mem_rsp_valid = 1'b1; mem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_total++;
            if ({is_req_ready_to_exu, is_req_valid_to_wbu, mem_req_valid, result_out_lsu} !== {3'b100, 32'h0})
                $display("FAIL midop_late_rsp: got rdy=%b wbv=%b req=%b res=%h exp rdy=1 wbv=0 req=0 res=0",
                         is_req_ready_to_exu, is_req_valid_to_wbu, mem_req_valid, result_out_lsu);
            else n_pass++;
            if (i == 0) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] rk;
        logic [1:0] wk;
        for (int n = 0; n < 60; n++) begin
            rk = 3'($urandom_range(0, 5));
            wk = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 2) == 0) begin rk = NO_MEM_READ; wk = NO_MEM_WRITE; end
            do_op($sformatf("rand%0d", n), rk, wk, $urandom, $urandom, 5'($urandom), 1'($urandom),
                  16'($urandom), $urandom, ($urandom_range(0, 7) == 0),
                  $urandom_range(0, 3), int'($urandom_range(0, 3)) - 1, $urandom_range(0, 2));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        is_req_valid_from_exu = 1'b0; addr_in_lsu = '0; lsu_write_data_in_lsu = '0;
        lsu_read_in_lsu = NO_MEM_READ; lsu_write_in_lsu = NO_MEM_WRITE;
        rd_in_lsu = '0; reg_write_in_lsu = 1'b0; ctrl_in_lsu = '0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rdata = '0; mem_rsp_err = 1'b0;
        is_req_ready_from_wbu = 1'b0;

        test_reset();
        test_alu_passthrough();
        test_store_lanes();
        test_loads();
        test_backpressure();
        test_bus_error();
        test_reset_midop();
        test_back_to_back();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ysyx_25040129_lsu.md
Name: ysyx_25040129_lsu

Overview:
Memory-access stage that sits between the EXU and the WBU and is the receiving end of the EXU→LSU valid/ready request. It accepts one instruction per handshake. Loads and stores run over a single-outstanding request/response data bus. Non-memory instructions pass through to WBU with one cycle of registering. It drives byte lanes and write strobes for stores, and extracts and sign- or zero-extends load data.

Parameters:
XLEN, 32, data/address width
REGS_DIG, 5, register index width (matches ysyx_25040129_REGS_DIG)
CTRL_W, 16, width of opaque pass-through control bundle (csr write/addr, ecall, mret, fence_i)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
is_req_valid_from_exu  in  1  EXU request valid
is_req_ready_to_exu  out  1  LSU can accept
addr_in_lsu  in  XLEN  EXU result (mem address or ALU result)
lsu_write_data_in_lsu  in  XLEN  store data (rs2)
lsu_read_in_lsu  in  3  load kind (package encoding)
lsu_write_in_lsu  in  2  store kind (package encoding)
rd_in_lsu  in  REGS_DIG  destination register
reg_write_in_lsu  in  1  rd write enable
ctrl_in_lsu  in  CTRL_W  pass-through control
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_we  out  1  1=store
mem_addr  out  XLEN  byte address, unmodified
mem_wdata  out  XLEN  lane-shifted store data
mem_wstrb  out  4  byte strobes
mem_rsp_valid  in  1  bus response (one cycle pulse)
mem_rdata  in  XLEN  word-aligned read data
mem_rsp_err  in  1  bus error with response
is_req_valid_to_wbu  out  1  result valid
is_req_ready_from_wbu  in  1  WBU accepts
result_out_lsu  out  XLEN  writeback value
rd_out_lsu  out  REGS_DIG  latched rd
reg_write_out_lsu  out  1  latched write enable
ctrl_out_lsu  out  CTRL_W  latched control
lsu_err_out  out  1  access fault, valid with is_req_valid_to_wbu
is_data_forward_valid_from_lsu  out  1  result_out_lsu usable for forwarding

Behaviour:
- Interface: one clock clk; rst synchronous, active-high.
- FSM states: IDLE, BUS_REQ, BUS_WAIT, WB_HOLD. Reset puts the FSM in IDLE and clears every registered output to 0.
- is_req_ready_to_exu = (state==IDLE) && !rst. It is a function of registered state only and never of is_req_valid_from_exu. The EXU forwards this ready combinationally to the IDU, so this rule prevents a combinational loop.
- Accept when valid && ready: latch all inputs.
  - Load (read != NO_MEM_READ) or store (write != NO_MEM_WRITE) → BUS_REQ.
  - Otherwise result = addr_in_lsu → WB_HOLD.
  - Latency for a non-memory op: 1 cycle.
- Read and write both non-zero is illegal. Treat it as a store.
- BUS_REQ: mem_req_valid=1 with stable mem_* fields until mem_req_ready, then go to BUS_WAIT. A response in the same cycle as the accept is legal: go straight to WB_HOLD.
- BUS_WAIT: on mem_rsp_valid, compute the result and go to WB_HOLD. Only one access is outstanding at a time.
- Store lanes, off = addr[1:0]:
  - SB: wdata = {4{data[7:0]}}, wstrb = 4'b0001<<off.
  - SH: wdata = {2{data[15:0]}}, wstrb = 4'b0011<<off.
  - SW: wdata = data, wstrb = 4'b1111.
  - Store result = 0 and reg_write is forced 0.
- Load extract: byte = rdata[8*off+:8], half = rdata[16*off[1]+:16]. LB and LH sign-extend; LBU and LHU zero-extend; LW uses the full word.
- mem_rsp_err=1: result=0, reg_write_out_lsu=0, lsu_err_out=1.
- WB_HOLD:
  - is_req_valid_to_wbu=1; all outputs are held stable until is_req_ready_from_wbu, then go to IDLE.
  - No new accept while in WB_HOLD. Peak throughput is one instruction per 2 cycles for non-memory ops.
- is_data_forward_valid_from_lsu = (state==WB_HOLD) && reg_write_out_lsu.
- Reset mid-operation: return to IDLE on the next edge and drop any in-flight access. A late mem_rsp_valid while in IDLE is ignored. The bus responder shares rst.
- The address is never modified or realigned; the bus sees the full byte address.

Optional Feature:
Macro YSYX_25040129_LSU_ALIGN_CHECK_EN.
- Defined: a misaligned access (LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0) issues no bus request and goes IDLE→WB_HOLD with lsu_err_out=1, result=0, reg_write_out_lsu=0.
- Undefined: there is no check. A misaligned halfword at off=3 reads rdata[31:16], and the bus receives whatever is issued. lsu_err_out is driven only by mem_rsp_err.

Decomposition:
- Package ysyx_25040129_lsu_pkg holds:
  - load encodings NO_MEM_READ=0, LB, LH, LW, LBU, LHU;
  - store encodings NO_MEM_WRITE=0, SB, SH, SW;
  - FSM state enum;
  - WORD_T=4.
- One sub-module, ysyx_25040129_lsu_align: combinational store lane/strobe generation plus load extract/extend, shared by the FSM datapath.

Test Plan:
- ALU pass-through: addr_in=0x0000_1234, reg_write=1, rd=5, WBU ready → is_req_valid_to_wbu the next cycle, result=0x1234, rd_out=5, no mem_req_valid.
- SB addr=0x8000_0003, data=0x0000_00AB → mem_wstrb=1000, mem_wdata=0xABABABAB, mem_we=1; response → result 0, reg_write_out=0.
- LB addr=0x8000_0002, rdata=0x1280_FF00 → result 0xFFFF_FF80. LBU at the same address → 0x0000_0080. LHU addr=...2 → 0x0000_1280.
- Backpressure: mem_req_ready low 3 cycles then WBU ready low 2 cycles → mem_* and result stable throughout, is_req_ready_to_exu=0 until the WBU handshake.
- rst asserted in BUS_WAIT, then mem_rsp_valid one cycle later → FSM IDLE, no is_req_valid_to_wbu, is_req_ready_to_exu=1.
- With ALIGN_CHECK_EN: LW addr=0x8000_0002 → no mem_req_valid, lsu_err_out=1, result=0. With mem_rsp_err on an aligned LW → lsu_err_out=1 in both builds.
